ps2_arrow_tracker: RTL and testbench
====================================

# ps2_arrow_tracker

Sequences the raw byte stream from `PS2_Controller` into debounced arrow-key state and a scheduled movement command. It sits between `PS2_Controller` (`received_data` / `received_data_en`) and game or display logic. Key-down state is tracked across make, break and `E0`-extended sequences. A single `dir` output uses last-pressed priority, and one-cycle `move_pulse` strobes follow a typematic schedule.

## Interface
- `INIT_DELAY`, 25_000_000: cycles from a new direction to its first repeat pulse (0.5 s at 50 MHz).
- `REPEAT_PERIOD`, 5_000_000: cycles between subsequent repeat pulses.
- `PREFIX_TIMEOUT`, 500_000: cycles a pending `E0`/`F0` prefix survives without a following byte.
- `CLOCK_50`  in  1  system clock; all state on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `received_data`  in  8  scan-code byte from `PS2_Controller`.
- `received_data_en`  in  1  one-cycle strobe; `received_data` valid this cycle.
- `key_held`  out  4  {left, right, up, down}, one bit per currently held key.
- `dir_valid`  out  1  at least one arrow held.
- `dir`  out  2  active direction: 0 up, 1 down, 2 left, 3 right.
- `move_pulse`  out  1  one-cycle movement strobe.
- `seq_err`  out  1  one-cycle strobe on a dropped prefix (timeout).

## Operation
- Parser FSM states:
  - IDLE: `E0` goes to EXT; `F0` goes to BRK; any other code is a make.
  - EXT: `F0` goes to EXT_BRK; a repeated `E0` stays in EXT; any other code is an extended make, then IDLE.
  - BRK: a repeated `F0` stays in BRK; any other code is a break, then IDLE.
  - EXT_BRK: any code is an extended break, then IDLE.
- Arrow codes are 6B left, 74 right, 75 up, 72 down. They are accepted both extended and non-extended, so keypad 4/6/8/2 alias the arrows. All other codes change only FSM state.
- A make sets the key's bit in `key_held`. A break clears it. A make for an already-held key is a host auto-repeat; it does not change state and does not pulse.
- Direction selection:
  - A make of an arrow sets `dir` to that key (last-pressed wins).
  - A break of the key currently in `dir` falls back to the highest-priority held key: up > down > left > right.
  - With no key held, `dir_valid` = 0 and `dir` holds its last value.
- Scheduling:
  - `move_pulse` fires whenever `dir` changes to a new value with `dir_valid` = 1, or `dir_valid` rises.
  - It also fires on typematic expiries (see Configuration).
- Prefix timeout:
  - In EXT, BRK or EXT_BRK, a counter runs.
  - After `PREFIX_TIMEOUT` cycles with no strobe: return to IDLE, pulse `seq_err`, leave `key_held` unchanged.
  - Any strobe reloads the counter.

## Timing
- Reset values: FSM IDLE; `key_held` = 0; `dir_valid` = 0; `dir` = 0; `move_pulse` = 0; `seq_err` = 0; all counters 0.
- Latency: a strobe at cycle t updates `key_held`, `dir` and `dir_valid`, and emits the initial `move_pulse`, at cycle t+1. All outputs are registered.
- Strobes may arrive on back-to-back cycles; each is consumed. No byte is dropped.
- Simultaneous timeout and strobe in the same cycle: the strobe wins, is processed in the current state, and `seq_err` stays 0.
- Repeat counter:
  - Resets to 0 on every `dir` change or `dir_valid` fall.
  - Saturates rather than wraps.
- Reset asserted mid-sequence returns immediately to reset values. A partial prefix is discarded.

## Configuration
- `PS2_TYPEMATIC_EN` defined: while `dir_valid` stays 1 and `dir` stays constant, `move_pulse` fires `INIT_DELAY` cycles after the initial pulse, then every `REPEAT_PERIOD` cycles.
- `PS2_TYPEMATIC_EN` undefined:
  - Only the initial pulse per direction change is generated.
  - The repeat counter is not synthesized.
  - `INIT_DELAY` and `REPEAT_PERIOD` are ignored.

## Structure
- Shared package `ps2_pkg` holds:
  - scan-code constants `SC_EXT` (E0), `SC_BRK` (F0), `SC_LEFT`, `SC_RIGHT`, `SC_UP`, `SC_DOWN`;
  - the `dir_t` enum (UP = 0, DOWN, LEFT, RIGHT);
  - the parser state enum.
- Sub-module `ps2_repeat_timer` owns the `INIT_DELAY`/`REPEAT_PERIOD` counter. Ports: `CLOCK_50`, `resetn`, `restart`, `active`, `tick`. It is instantiated only under `PS2_TYPEMATIC_EN`.
- Counter widths are `$clog2(param+1)`.

## Test plan
Bench parameters: `INIT_DELAY` = 8, `REPEAT_PERIOD` = 4, `PREFIX_TIMEOUT` = 16.

- Bytes E0 75 -> `key_held` = 0010, `dir` = 0, `dir_valid` = 1, one `move_pulse` one cycle after the 75 strobe. Then E0 F0 75 -> `key_held` = 0000, `dir_valid` = 0, no pulse.
- Hold left (E0 6B), then press up (E0 75) -> `dir` 2 then 0, two pulses. Release up (E0 F0 75) -> `dir` = 2, with `key_held` = 1000 and one pulse.
- `PS2_TYPEMATIC_EN`, hold right with no further bytes -> pulses at +1, +9, +13, +17 cycles after the 74 strobe. Without the macro, only the +1 pulse.
- Host repeat: E0 72 sent three times -> a single pulse (typematic off), `key_held` = 0001.
- E0 alone, then 16 idle cycles -> `seq_err` pulses once and FSM returns to IDLE. The next 74 is a make: `dir` = 3.
- Assert `resetn` low between F0 and 6B while left is held -> all outputs 0. After release, the byte 6B is a make, not a break: `key_held` = 1000.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared scan-code constants, direction and parser-state types for the
// PS/2 arrow-key tracker.
package ps2_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } parse_state_t;

  // Extended and plain codes share values, so keypad 4/6/8/2 alias the arrows.
  function automatic logic is_arrow(input logic [7:0] code);
    return (code == SC_LEFT) || (code == SC_RIGHT) ||
           (code == SC_UP)   || (code == SC_DOWN);
  endfunction

  function automatic dir_t arrow_dir(input logic [7:0] code);
    case (code)
      SC_UP:   return UP;
      SC_DOWN: return DOWN;
      SC_LEFT: return LEFT;
      default: return RIGHT;
    endcase
  endfunction

  // Bit position of each key inside key_held = {left, right, up, down}.
  function automatic logic [3:0] key_mask(input dir_t d);
    case (d)
      UP:      return 4'b0010;
      DOWN:    return 4'b0001;
      LEFT:    return 4'b1000;
      default: return 4'b0100;
    endcase
  endfunction

endpackage

// File: rtl/ps2_arrow_tracker_if.sv
// Byte-stream input and arrow-state outputs of the PS/2 arrow tracker.
interface ps2_arrow_tracker_if;
  import ps2_pkg::*;

  logic [7:0] received_data;
  logic       received_data_en;
  logic [3:0] key_held;
  logic       dir_valid;
  dir_t       dir;
  logic       move_pulse;
  logic       seq_err;

  // Byte source / consumer of the movement outputs.
  modport master (
    output received_data, received_data_en,
    input  key_held, dir_valid, dir, move_pulse, seq_err
  );

  // The tracker itself.
  modport slave (
    input  received_data, received_data_en,
    output key_held, dir_valid, dir, move_pulse, seq_err
  );

endinterface

// File: rtl/ps2_repeat_timer.sv
// Typematic schedule: after a restart, tick once INIT_DELAY cycles later,
// then every REPEAT_PERIOD cycles while active stays high.
module ps2_repeat_timer #(
  parameter int INIT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  logic CLOCK_50,
  input  logic resetn,
  input  logic restart,
  input  logic active,
  output logic tick
);
  localparam int MAX_DLY = (INIT_DELAY > REPEAT_PERIOD) ? INIT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(MAX_DLY + 1);
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_DELAY - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rep_q, rep_d;

  // Count toward the current phase limit; saturate instead of wrapping.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    cnt_d = cnt_q;
    rep_d = rep_q;
    tick  = 1'b0;
    if (restart || !active) begin
      cnt_d = '0;
      rep_d = 1'b0;
    end else if (cnt_q == (rep_q ? REP_LAST : INIT_LAST)) begin
      tick  = 1'b1;
      cnt_d = '0;
      rep_d = 1'b1;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter and phase registers.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
      rep_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rep_q <= rep_d;
    end
  end

endmodule

// File: rtl/ps2_arrow_tracker.sv
// PS/2 arrow-key tracker: parses make/break/E0 byte sequences into held-key
// state, a last-pressed direction and movement strobes.
// Define PS2_TYPEMATIC_EN to add repeat pulses while a direction is held.
module ps2_arrow_tracker
  import ps2_pkg::*;
#(
  parameter int INIT_DELAY     = 25_000_000,
  parameter int REPEAT_PERIOD  = 5_000_000,
  parameter int PREFIX_TIMEOUT = 500_000
) (
  input logic                CLOCK_50,
  input logic                resetn,
  ps2_arrow_tracker_if.slave bus
);
  localparam int PTO_W = $clog2(PREFIX_TIMEOUT + 1);
  localparam logic [PTO_W-1:0] PTO_LAST = PTO_W'(PREFIX_TIMEOUT - 1);

  parse_state_t     state_q, state_d;
  logic [PTO_W-1:0] pto_q, pto_d;
  logic [3:0]       key_q, key_d;
  dir_t             dir_q, dir_d;
  logic             dir_valid_q, dir_valid_d;
  logic             move_pulse_q, move_pulse_d;
  logic             seq_err_q, seq_err_d;
  logic             is_make, is_break, new_dir;
  logic             rpt_restart, rpt_tick;
  logic [7:0]       code;
  dir_t             hit_dir;
  logic [3:0]       hit_mask;

  assign code     = bus.received_data;
  assign hit_dir  = arrow_dir(code);
  assign hit_mask = key_mask(hit_dir);

  // Parser next state, make/break classification and prefix timeout.
  // A strobe always takes precedence over an expiring prefix.
  always_comb begin
    state_d   = state_q;
    is_make   = 1'b0;
    is_break  = 1'b0;
    seq_err_d = 1'b0;
    if (bus.received_data_en) begin
      unique case (state_q)
        IDLE: begin
          if (code == SC_EXT)      state_d = EXT;
          else if (code == SC_BRK) state_d = BRK;
          else                     is_make = 1'b1;
        end
        EXT: begin
          if (code == SC_BRK)      state_d = EXT_BRK;
          else if (code != SC_EXT) begin
            is_make = 1'b1;
            state_d = IDLE;
          end
        end
        BRK: begin
          if (code != SC_BRK) begin
            is_break = 1'b1;
            state_d  = IDLE;
          end
        end
        EXT_BRK: begin
          is_break = 1'b1;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && pto_q == PTO_LAST) begin
      seq_err_d = 1'b1;
      state_d   = IDLE;
    end
    pto_d = (bus.received_data_en || state_q == IDLE || seq_err_d) ? '0 : pto_q + 1'b1;
  end

  // Held-key bookkeeping, last-pressed direction and fallback on release.
  always_comb begin
    key_d = key_q;
    dir_d = dir_q;
    if (is_arrow(code)) begin
      if (is_make && (key_q & hit_mask) == 4'b0000) begin
        key_d = key_q | hit_mask;
        dir_d = hit_dir;
      end else if (is_break) begin
        key_d = key_q & ~hit_mask;
        if (dir_q == hit_dir) begin
          if (key_d[1])      dir_d = UP;
          else if (key_d[0]) dir_d = DOWN;
          else if (key_d[3]) dir_d = LEFT;
          else if (key_d[2]) dir_d = RIGHT;
        end
      end
    end
    dir_valid_d  = |key_d;
    new_dir      = dir_valid_d && (!dir_valid_q || dir_d != dir_q);
    rpt_restart  = new_dir || (dir_valid_q && !dir_valid_d);
    move_pulse_d = new_dir || rpt_tick;
  end

`ifdef PS2_TYPEMATIC_EN
  ps2_repeat_timer #(
    .INIT_DELAY    (INIT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_repeat_timer (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .restart  (rpt_restart),
    .active   (dir_valid_q),
    .tick     (rpt_tick)
  );
`else
  // Without typematic repeat only the initial pulse per change exists.
  logic unused_cfg;
  assign rpt_tick   = 1'b0;
  assign unused_cfg = ^{INIT_DELAY, REPEAT_PERIOD, rpt_restart};
`endif

  // All state and outputs registered; reset discards any partial prefix.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      pto_q        <= '0;
      key_q        <= 4'b0000;
      dir_q        <= UP;
      dir_valid_q  <= 1'b0;
      move_pulse_q <= 1'b0;
      seq_err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q      <= state_d;
      pto_q        <= pto_d;
      key_q        <= key_d;
      dir_q        <= dir_d;
      dir_valid_q  <= dir_valid_d;
      move_pulse_q <= move_pulse_d;
      seq_err_q    <= seq_err_d;
    end
  end

  assign bus.key_held   = key_q;
  assign bus.dir        = dir_q;
  assign bus.dir_valid  = dir_valid_q;
  assign bus.move_pulse = move_pulse_q;
  assign bus.seq_err    = seq_err_q;

endmodule

// File: tb/tb_ps2_arrow_tracker.sv
// Scoreboard bench for ps2_arrow_tracker: each driven byte pushes the
// expected registered outputs for the following cycle; a negedge monitor pops
// and compares them. Honours PS2_TYPEMATIC_EN for the repeat-pulse checks.
module tb_ps2_arrow_tracker;

  typedef struct {
    int         cyc;
    logic [3:0] kh;
    logic       dv;
    logic [1:0] dir;
    logic       mp;
    logic       mp_chk;
  } exp_t;

  logic clk;
  logic resetn;
  int   cyc = 0;
  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   obs_pulses = 0;
  int   exp_pulses = 0;
  logic mp_chk_en = 1'b1;
  exp_t sb[$];
  bit   pulse_at[int];
  bit   seq_at[int];

  // Reference model state: held[] indexed up=0, down=1, left=2, right=3.
  bit   held[4];
  int   mdir = 0;
  bit   m_ext = 0;
  bit   m_brk = 0;

  ps2_arrow_tracker_if bus ();

  ps2_arrow_tracker #(
    .INIT_DELAY     (8),
    .REPEAT_PERIOD  (4),
    .PREFIX_TIMEOUT (16)
  ) dut (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: log strobes and compare scoreboard entries due this cycle.
  always @(negedge clk) begin
    exp_t e;
    pulse_at[cyc] = (bus.move_pulse === 1'b1);
    seq_at[cyc]   = (bus.seq_err === 1'b1);
    if (bus.move_pulse === 1'b1) obs_pulses++;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      check("sb_on_time", cyc, e.cyc);
      check("key_held", bus.key_held, e.kh);
      check("dir_valid", bus.dir_valid, e.dv);
      check("dir", bus.dir, e.dir);
      if (e.mp_chk) check("move_pulse", bus.move_pulse, e.mp);
    end
  end

  function automatic int arrow_idx(input logic [7:0] b);
    case (b)
      8'h75:   return 0;
      8'h72:   return 1;
      8'h6B:   return 2;
      8'h74:   return 3;
      default: return -1;
    endcase
  endfunction

  function automatic bit m_valid();
    return held[0] | held[1] | held[2] | held[3];
  endfunction

  task automatic m_key(input bit make, input logic [7:0] b);
    int  k;
    bit  found;
    k = arrow_idx(b);
    if (k < 0) return;
    if (make) begin
      if (!held[k]) begin
        held[k] = 1'b1;
        mdir    = k;
      end
    end else begin
      held[k] = 1'b0;
      if (mdir == k) begin
        found = 1'b0;
        for (int p = 0; p < 4; p++)
          if (!found && held[p]) begin
            mdir  = p;
            found = 1'b1;
          end
      end
    end
  endtask

  task automatic m_byte(input logic [7:0] b);
    if (m_brk) begin
      if (!(b == 8'hF0 && !m_ext)) begin
        m_key(1'b0, b);
        m_ext = 1'b0;
        m_brk = 1'b0;
      end
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else begin
      m_key(1'b1, b);
      m_ext = 1'b0;
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 4; i++) held[i] = 1'b0;
    mdir  = 0;
    m_ext = 1'b0;
    m_brk = 1'b0;
  endtask

  // Drive one byte for one cycle and queue the outputs expected next cycle.
  task automatic send_byte(input logic [7:0] b);
    exp_t e;
    bit   pv;
    int   pd;
    pv = m_valid();
    pd = mdir;
    m_byte(b);
    e.cyc    = cyc + 1;
    e.kh     = {held[2], held[3], held[0], held[1]};
    e.dv     = m_valid();
    e.dir    = 2'(mdir);
    e.mp     = m_valid() && (!pv || mdir != pd);
    e.mp_chk = mp_chk_en;
    if (e.mp) exp_pulses++;
    sb.push_back(e);
    bus.received_data    = b;
    bus.received_data_en = 1'b1;
    @(posedge clk);
    #1;
    bus.received_data_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input string tag);
    check({tag, "_sb_empty"}, sb.size(), 0);
    sb.delete();
    resetn = 1'b0;
    #1;
    check({tag, "_key_held"}, bus.key_held, 4'b0000);
    check({tag, "_dir_valid"}, bus.dir_valid, 1'b0);
    check({tag, "_dir"}, bus.dir, 2'd0);
    check({tag, "_move_pulse"}, bus.move_pulse, 1'b0);
    check({tag, "_seq_err"}, bus.seq_err, 1'b0);
    m_reset();
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  function automatic int count_seq(input int a, input int b);
    int n = 0;
    for (int c = a; c <= b; c++) if (seq_at.exists(c) && seq_at[c]) n++;
    return n;
  endfunction

  logic [7:0] pool [7] = '{8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h75, 8'h72, 8'h1C};

  initial begin
    int  s;
    bit  exp_p;
    resetn               = 1'b1;
    bus.received_data    = 8'h00;
    bus.received_data_en = 1'b0;
    #3;
    do_reset("rst0");

    // Extended up press and release.
    send_byte(8'hE0); send_byte(8'h75);
    idle(2);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    idle(2);

    // Last-pressed priority and fallback on release.
    do_reset("rst1");
    send_byte(8'hE0); send_byte(8'h6B);
    send_byte(8'hE0); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    idle(2);

    // Hold right with no further bytes: typematic schedule.
    do_reset("rst2");
    send_byte(8'hE0);
    s = cyc;
    send_byte(8'h74);
    idle(20);
    for (int c = s + 1; c <= s + 19; c++) begin
      exp_p = (c == s + 1);
`ifdef PS2_TYPEMATIC_EN
      exp_p = exp_p || (c == s + 9) || (c == s + 13) || (c == s + 17);
`endif
      check("rpt_pulse", pulse_at[c], exp_p);
    end

    // Host auto-repeat of down: single pulse.
    do_reset("rst3");
    repeat (3) begin
      send_byte(8'hE0); send_byte(8'h72);
    end
    idle(2);

    // Dangling E0 times out, then 74 is a plain make.
    do_reset("rst4");
    send_byte(8'hE0);
    s = cyc - 1;
    idle(20);
    check("seq_err_early", count_seq(s + 1, s + 10), 0);
    check("seq_err_once", count_seq(s + 1, s + 20), 1);
    m_ext = 1'b0;
    send_byte(8'h74);
    idle(2);

    // Strobe arriving on the expiry cycle wins; no seq_err.
    do_reset("rst5");
    send_byte(8'hE0);
    s = cyc - 1;
    idle(15);
    send_byte(8'h75);
    idle(4);
    check("seq_err_strobe_wins", count_seq(s + 1, s + 20), 0);

    // Reset between F0 and 6B discards the pending break.
    do_reset("rst6");
    send_byte(8'h6B);
    send_byte(8'hF0);
    idle(1);
    do_reset("rst_mid");
    send_byte(8'h6B);
    idle(2);

    // Back-to-back random bursts over arrows, prefixes and a non-arrow code.
    do_reset("rst7");
`ifdef PS2_TYPEMATIC_EN
    mp_chk_en = 1'b0;
`endif
    repeat (6) begin
      repeat (8) send_byte(pool[$urandom_range(0, 6)]);
      idle(2);
    end
    mp_chk_en = 1'b1;
    idle(2);

    check("sb_drained", sb.size(), 0);
`ifndef PS2_TYPEMATIC_EN
    check("pulse_total", obs_pulses, exp_pulses);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
